clock_set_ctrl: RTL

// Time-setting controller for the HH:MM:SS digital clock datapath (counter chain + seven-segment decode).

---
 rtl/clock_set_ctrl_pkg.sv | 28 ++
 rtl/clock_set_ctrl_btn_debounce.sv | 57 +++++
 rtl/clock_set_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock time-setting controller: field widths,
// field limits, FSM state codes and wrap-by-compare increment helpers.
package clock_set_ctrl_pkg;

  localparam int unsigned HR_W    = 5;
  localparam int unsigned MS_W    = 6;
  localparam int unsigned STATE_W = 3;

  localparam logic [HR_W-1:0] HR_MAX = HR_W'(23);
  localparam logic [MS_W-1:0] MS_MAX = MS_W'(59);

  localparam logic [STATE_W-1:0] ST_RUN     = 3'd0;
  localparam logic [STATE_W-1:0] ST_SET_HR  = 3'd1;
  localparam logic [STATE_W-1:0] ST_SET_MIN = 3'd2;
  localparam logic [STATE_W-1:0] ST_SET_SEC = 3'd3;
  localparam logic [STATE_W-1:0] ST_APPLY   = 3'd4;

  // Next hour value, wrapping 23 -> 0.
  function automatic logic [HR_W-1:0] hr_wrap_inc(input logic [HR_W-1:0] v);
    return (v == HR_MAX) ? '0 : v + HR_W'(1);
  endfunction

  // Next minute/second value, wrapping 59 -> 0.
  function automatic logic [MS_W-1:0] ms_wrap_inc(input logic [MS_W-1:0] v);
    return (v == MS_MAX) ? '0 : v + MS_W'(1);
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debounce and
// rising-edge detect producing a one-cycle press pulse.
module clock_set_ctrl_btn_debounce #(
  parameter int unsigned DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // One-cycle pulse on the rising edge of the accepted level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: steps hours -> minutes -> seconds with two
// buttons, freezes the counter chain while editing, blinks the edited field
// and issues a one-cycle load of the shadow time on exit.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 20,
  parameter int unsigned BLINK_DIV      = 25000000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic [HR_W-1:0]    cur_hr,
  input  logic [MS_W-1:0]    cur_min,
  input  logic [MS_W-1:0]    cur_sec,
  output logic               run_en,
  output logic               load,
  output logic [HR_W-1:0]    load_hr,
  output logic [MS_W-1:0]    load_min,
  output logic [MS_W-1:0]    load_sec,
  output logic               blank_hr,
  output logic               blank_min,
  output logic               blank_sec,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned BL_W = $clog2(BLINK_DIV + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic               mode_p;
  logic               inc_p;
  logic               in_set;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [TO_W-1:0]    idle_q;
  logic [TO_W-1:0]    idle_d;
  logic [BL_W-1:0]    blink_q;
  logic [BL_W-1:0]    blink_d;
  logic               phase_q;
  logic               phase_d;
  logic [HR_W-1:0]    hr_d;
  logic [MS_W-1:0]    min_d;
  logic [MS_W-1:0]    sec_d;

  clock_set_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .press (mode_p)
  );

  clock_set_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_inc),
    .press (inc_p)
  );

  assign in_set  = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN) ||
                   (state_q == ST_SET_SEC);
  assign state_o = state_q;

  // State, shadow-field, idle-timeout and blink next-value logic.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    blink_d = blink_q;
    phase_d = phase_q;
    hr_d    = load_hr;
    min_d   = load_min;
    sec_d   = load_sec;

    case (state_q)
      ST_RUN: begin
        if (mode_p) begin
          hr_d    = cur_hr;
          min_d   = cur_min;
          sec_d   = cur_sec;
          state_d = ST_SET_HR;
        end
      end
      ST_SET_HR: begin
        if (mode_p)     state_d = ST_SET_MIN;
        else if (inc_p) hr_d    = hr_wrap_inc(load_hr);
      end
      ST_SET_MIN: begin
        if (mode_p)     state_d = ST_SET_SEC;
        else if (inc_p) min_d   = ms_wrap_inc(load_min);
      end
      ST_SET_SEC: begin
        if (mode_p)     state_d = ST_APPLY;
        else if (inc_p) sec_d   = ms_wrap_inc(load_sec);
      end
      ST_APPLY: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (in_set) begin
      // Any press restarts the idle window; expiry abandons the edit.
      if (mode_p || inc_p) begin
        idle_d = '0;
      end else if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        idle_d  = '0;
        state_d = ST_RUN;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end

      // An accepted increment restarts the blink so the new value shows.
      if (inc_p && !mode_p) begin
        blink_d = '0;
        phase_d = 1'b0;
      end else if (blink_q == BL_W'(BLINK_DIV - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BL_W'(1);
      end
    end else begin
      idle_d  = '0;
      blink_d = '0;
      phase_d = 1'b0;
    end
  end

  // FSM state, counters and shadow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      idle_q   <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b0;
      load_hr  <= '0;
      load_min <= '0;
      load_sec <= '0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      load_hr  <= hr_d;
      load_min <= min_d;
      load_sec <= sec_d;
    end
  end

  // Registered control outputs, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_en    <= 1'b1;
      load      <= 1'b0;
      blank_hr  <= 1'b0;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      run_en    <= (state_d == ST_RUN);
      load      <= (state_d == ST_APPLY);
      blank_hr  <= (state_d == ST_SET_HR)  & phase_d;
      blank_min <= (state_d == ST_SET_MIN) & phase_d;
      blank_sec <= (state_d == ST_SET_SEC) & phase_d;
    end
  end

endmodule
